uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- UART transmit end of the serial link; it is the counterpart of the existing 16x-oversampling receiver.
- Accepts bytes from the host through a small write FIFO.
- Serialises each byte as start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits.
- Runs on the same 16x-baud clken tick as the receiver, so a single baud generator drives both directions.

Parameters:
- PARITY, default 0: 0 = none, 1 = even, 2 = odd; any other value is treated as 0.
- STOP_BITS, default 1: number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, default 4: write FIFO entries; power of two, minimum 2.

Ports:
- clk_50m  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clken  input  1  16x-baud tick, one clk_50m cycle wide.
- din  input  8  byte to transmit.
- wr_en  input  1  write din into FIFO this cycle.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- overflow  output  1  sticky: a write was attempted while full.
- ovf_clr  input  1  clears overflow.
- tx_busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
- tx  output  1  serial line; idles high.

Behaviour:
- Reset (async assert, sync release): tx=1, full=0, overflow=0, tx_busy=0, FIFO empty, FSM=IDLE, tick=0.
- FIFO write:
  - wr_en with full=0: din is stored and is visible to the FSM the next cycle.
  - wr_en with full=1: write dropped and overflow<=1, even if a pop occurs in the same cycle.
  - full and empty are registered; a write and a pop in the same cycle leave the count unchanged.
- overflow clear: ovf_clr clears overflow; if ovf_clr and a dropped write occur in the same cycle, overflow ends up 1.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter and a 3-bit bit index are used. All FSM actions happen only on cycles with clken=1.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty: pop into the shift register, tx<=0, tick<=0, go to START.
- Bit states (START, DATA, PARITY, STOP):
  - tick increments on each clken. The bit ends on the clken where tick==15, so each bit lasts exactly 16 clken pulses.
  - tx is updated only at bit boundaries.
- START end: tx<=data[0], bit index<=0, go to DATA.
- DATA end:
  - bit index<7: advance the index; tx<=next data bit.
  - bit index==7 and PARITY!=0: tx<=parity, go to PARITY. Even parity = XOR of the data bits; odd parity = its inverse.
  - bit index==7 and PARITY==0: tx<=1, go to STOP.
- PARITY end: tx<=1, go to STOP.
- STOP:
  - Lasts 16*STOP_BITS clken pulses; a stop-bit counter extends the tick count for 2 stop bits.
  - At its end, if the FIFO is non-empty: pop, tx<=0, go to START. Frames are back to back with no idle gap.
  - Otherwise go to IDLE with tx=1.
- Frame length in clken pulses: 16*(10 + (PARITY!=0) + (STOP_BITS-1)).
- The data byte is captured at pop time; later FIFO writes never alter a frame in flight.
- clken=0 freezes the FSM and tx. FIFO writes still proceed.
- Reset asserted mid-frame: tx goes to 1 immediately (asynchronously), the frame is abandoned and the FIFO is flushed.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is one bit wider than the pointers.

Test Plan:
1. PARITY=0, STOP_BITS=1, clken tied high, write 0x55: tx low 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then high 16 cycles; tx_busy falls after 160 ticks; idle tx=1.
2. Write 0xA3 then 0x3C on consecutive cycles: two 160-tick frames with the second start bit directly after the first stop bit (no gap); decoded LSB-first bits 1,1,0,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
3. PARITY=1, write 0x07: parity bit 1, frame 176 ticks. PARITY=2, write 0x07: parity bit 0. STOP_BITS=2: stop high 32 ticks.
4. clken held low, write 5 bytes: full=1 after the 4th write; 5th dropped; overflow=1 and stays 1. Pulse ovf_clr: overflow=0. Release clken: exactly 4 frames are sent, with the first four bytes in order.
5. Deassert rst_n halfway through a data bit: tx=1 in the same cycle, tx_busy=0, full=0. After release, a new write of 0xF0 produces a clean complete frame.
6. Random clken gaps (1-in-3 duty): every bit still spans exactly 16 clken pulses, and tx changes only on cycles with clken=1.

Source files
------------

// File: rtl/uart_transmitter_if.sv
// Host-side bundle of the UART transmitter: byte writes, FIFO status, baud tick and serial line.
// master = host/driver side, slave = transmitter side.
interface uart_transmitter_if;
    logic       clken;
    logic [7:0] din;
    logic       wr_en;
    logic       full;
    logic       overflow;
    logic       ovf_clr;
    logic       tx_busy;
    logic       tx;

    modport master (
        output clken, din, wr_en, ovf_clr,
        input  full, overflow, tx_busy, tx
    );

    modport slave (
        input  clken, din, wr_en, ovf_clr,
        output full, overflow, tx_busy, tx
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmitter: FIFO-buffered 8N1/8E1/8O1 (1 or 2 stop) framing on a 16x-baud clken tick.
// A written byte reaches the FSM next cycle; no backpressure beyond full, writes while full are dropped into sticky overflow.
module uart_transmitter #(
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    uart_transmitter_if.slave host
);
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int CW       = AW + 1;
    localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
    localparam bit PAR_ODD  = (PARITY == 2);
    localparam bit TWO_STOP = (STOP_BITS == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic          push, pop;

    state_t        state_q, state_d;
    logic [3:0]    tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          par_bit;

    assign push    = host.wr_en && !full_q;
    assign par_bit = PAR_ODD ? ~(^data_q) : ^data_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        ovf_d    = ovf_q;
        if (host.ovf_clr)
            ovf_d = 1'b0;
        // A dropped write wins over a simultaneous clear.
        if (host.wr_en && full_q)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk_50m) begin
        if (push)
            mem_q[wr_ptr_q] <= host.din;
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        data_d  = data_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (host.clken) begin
            case (state_q)
                S_IDLE: begin
                    tx_d = 1'b1;
                    if (!empty_q) begin
                        pop     = 1'b1;
                        data_d  = mem_q[rd_ptr_q];
                        tx_d    = 1'b0;
                        tick_d  = '0;
                        state_d = S_START;
                    end
                end
                default: begin
                    // 4-bit tick wraps to 0 on the bit boundary, so the next bit starts at 0.
                    tick_d = tick_q + 4'd1;
                    if (tick_q == 4'd15) begin
                        case (state_q)
                            S_START: begin
                                tx_d    = data_q[0];
                                bit_d   = '0;
                                state_d = S_DATA;
                            end
                            S_DATA: begin
                                if (bit_q != 3'd7) begin
                                    bit_d = bit_q + 3'd1;
                                    tx_d  = data_q[bit_q + 3'd1];
                                end else if (PAR_EN) begin
                                    tx_d    = par_bit;
                                    state_d = S_PARITY;
                                end else begin
                                    tx_d    = 1'b1;
                                    stop_d  = 1'b0;
                                    state_d = S_STOP;
                                end
                            end
                            S_PARITY: begin
                                tx_d    = 1'b1;
                                stop_d  = 1'b0;
                                state_d = S_STOP;
                            end
                            default: begin
                                if (TWO_STOP && !stop_q) begin
                                    stop_d = 1'b1;
                                end else if (!empty_q) begin
                                    pop     = 1'b1;
                                    data_d  = mem_q[rd_ptr_q];
                                    tx_d    = 1'b0;
                                    state_d = S_START;
                                end else begin
                                    tx_d    = 1'b1;
                                    state_d = S_IDLE;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            data_q   <= '0;
            tx_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
        end
    end

    assign host.full     = full_q;
    assign host.overflow = ovf_q;
    assign host.tx_busy  = (state_q != S_IDLE) || !empty_q;
    assign host.tx       = tx_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three parameterisations share clock and reset, one is driven at a time.
module tb_uart_transmitter;
    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       clken_drv;
    logic [7:0] din_drv;
    logic       wr_drv;
    logic       clr_drv;
    int         sel;
    bit         rand_ck;
    logic       ck_edge;
    int         checks = 0;
    int         errors = 0;

    always #5 clk_50m = ~clk_50m;

    uart_transmitter_if if0 ();
    uart_transmitter_if if1 ();
    uart_transmitter_if if2 ();

    assign if0.clken   = (sel == 0) && clken_drv;
    assign if1.clken   = (sel == 1) && clken_drv;
    assign if2.clken   = (sel == 2) && clken_drv;
    assign if0.wr_en   = (sel == 0) && wr_drv;
    assign if1.wr_en   = (sel == 1) && wr_drv;
    assign if2.wr_en   = (sel == 2) && wr_drv;
    assign if0.ovf_clr = (sel == 0) && clr_drv;
    assign if1.ovf_clr = (sel == 1) && clr_drv;
    assign if2.ovf_clr = (sel == 2) && clr_drv;
    assign if0.din     = din_drv;
    assign if1.din     = din_drv;
    assign if2.din     = din_drv;

    uart_transmitter #(.PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (.clk_50m(clk_50m), .rst_n(rst_n), .host(if0));
    uart_transmitter #(.PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (.clk_50m(clk_50m), .rst_n(rst_n), .host(if1));
    uart_transmitter #(.PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (.clk_50m(clk_50m), .rst_n(rst_n), .host(if2));

    logic tx_sel, busy_sel;
    assign tx_sel   = (sel == 0) ? if0.tx      : (sel == 1) ? if1.tx      : if2.tx;
    assign busy_sel = (sel == 0) ? if0.tx_busy : (sel == 1) ? if1.tx_busy : if2.tx_busy;

    // ck_edge holds the clken level the DUT saw on the edge just taken.
    task automatic step();
        ck_edge = clken_drv;
        @(posedge clk_50m);
        #1;
        if (rand_ck) clken_drv = ($urandom_range(0, 2) == 0);
    endtask

    task automatic write_byte(input logic [7:0] b);
        din_drv = b;
        wr_drv  = 1'b1;
        step();
        wr_drv  = 1'b0;
    endtask

    // Bit k of the line must hold for clken pulses 16k..16k+15 after the start-bit pulse.
    task automatic capture(input int nbits, output logic [63:0] bits, output int bad);
        int n, p, idx, guard;
        bits = '1;
        bad  = 0;
        n    = 0;
        while (tx_sel !== 1'b0 && n < 3000) begin
            step();
            n++;
        end
        if (tx_sel !== 1'b0) begin
            bad = 1;
            return;
        end
        if (ck_edge !== 1'b1) bad++;
        bits[0] = 1'b0;
        p       = 0;
        guard   = 0;
        while (p < nbits * 16 && guard < 20000) begin
            step();
            guard++;
            if (ck_edge) p++;
            if (p < nbits * 16) begin
                idx = p / 16;
                if (ck_edge && (p % 16) == 0) bits[idx] = tx_sel;
                else if (tx_sel !== bits[idx]) bad++;
                if (busy_sel !== 1'b1) bad++;
            end
        end
        if (p < nbits * 16) bad++;
    endtask

    task automatic test_reset();
        checks++; if (if0.tx !== 1'b1)       begin errors++; $display("FAIL reset_tx0: got %b want 1", if0.tx); end
        checks++; if (if0.full !== 1'b0)     begin errors++; $display("FAIL reset_full: got %b want 0", if0.full); end
        checks++; if (if0.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", if0.overflow); end
        checks++; if (if0.tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b want 0", if0.tx_busy); end
        checks++; if (if1.tx !== 1'b1)       begin errors++; $display("FAIL reset_tx1: got %b want 1", if1.tx); end
        checks++; if (if2.tx !== 1'b1)       begin errors++; $display("FAIL reset_tx2: got %b want 1", if2.tx); end
    endtask

    task automatic test_single_frame();
        logic [63:0] bits;
        int bad;
        sel = 0; clken_drv = 1'b1;
        write_byte(8'h55);
        checks++; if (busy_sel !== 1'b1) begin errors++; $display("FAIL single_busy_rise: got %b want 1", busy_sel); end
        capture(10, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL single_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[9:0] !== {1'b1, 8'h55, 1'b0}) begin errors++; $display("FAIL single_bits: got %b want %b", bits[9:0], {1'b1, 8'h55, 1'b0}); end
        checks++; if (busy_sel !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b want 0", busy_sel); end
        repeat (5) step();
        checks++; if (tx_sel !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b want 1", tx_sel); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] bits;
        int bad;
        sel = 0; clken_drv = 1'b1;
        write_byte(8'hA3);
        write_byte(8'h3C);
        capture(20, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[19:0] !== {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA3, 1'b0}) begin errors++; $display("FAIL b2b_bits: got %b want %b", bits[19:0], {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA3, 1'b0}); end
        checks++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1) begin errors++; $display("FAIL b2b_end: got busy=%b tx=%b want busy=0 tx=1", busy_sel, tx_sel); end
    endtask

    task automatic test_parity_stop();
        logic [63:0] bits;
        int bad;
        sel = 1; clken_drv = 1'b1;
        write_byte(8'h07);
        capture(11, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL even_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[10:0] !== {1'b1, 1'b1, 8'h07, 1'b0}) begin errors++; $display("FAIL even_bits: got %b want %b", bits[10:0], {1'b1, 1'b1, 8'h07, 1'b0}); end
        checks++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1) begin errors++; $display("FAIL even_end: got busy=%b tx=%b want busy=0 tx=1", busy_sel, tx_sel); end
        sel = 2;
        write_byte(8'h07);
        capture(12, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL odd2s_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[11:0] !== {2'b11, 1'b0, 8'h07, 1'b0}) begin errors++; $display("FAIL odd2s_bits: got %b want %b", bits[11:0], {2'b11, 1'b0, 8'h07, 1'b0}); end
        checks++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1) begin errors++; $display("FAIL odd2s_end: got busy=%b tx=%b want busy=0 tx=1", busy_sel, tx_sel); end
    endtask

    task automatic test_overflow();
        logic [63:0] bits;
        int bad;
        sel = 0; clken_drv = 1'b0;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        checks++; if (if0.full !== 1'b0) begin errors++; $display("FAIL ovf_full3: got %b want 0", if0.full); end
        write_byte(8'h44);
        checks++; if (if0.full !== 1'b1) begin errors++; $display("FAIL ovf_full4: got %b want 1", if0.full); end
        checks++; if (if0.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", if0.overflow); end
        write_byte(8'h99);
        checks++; if (if0.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", if0.overflow); end
        repeat (5) step();
        checks++; if (if0.overflow !== 1'b1 || tx_sel !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got ovf=%b tx=%b want ovf=1 tx=1", if0.overflow, tx_sel); end
        clr_drv = 1'b1; step(); clr_drv = 1'b0;
        checks++; if (if0.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", if0.overflow); end
        clr_drv = 1'b1; write_byte(8'h77); clr_drv = 1'b0;
        checks++; if (if0.overflow !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop: got %b want 1", if0.overflow); end
        clr_drv = 1'b1; step(); clr_drv = 1'b0;
        clken_drv = 1'b1;
        capture(40, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL ovf_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[39:0] !== {1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}) begin
            errors++; $display("FAIL ovf_frames: got %b want %b", bits[39:0], {1'b1, 8'h44, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0});
        end
        checks++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1) begin errors++; $display("FAIL ovf_end: got busy=%b tx=%b want busy=0 tx=1", busy_sel, tx_sel); end
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] bits;
        int bad;
        sel = 0; clken_drv = 1'b1;
        write_byte(8'hF0);
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        write_byte(8'h04);
        checks++; if (if0.full !== 1'b1) begin errors++; $display("FAIL rst_pre_full: got %b want 1", if0.full); end
        repeat (21) step();
        checks++; if (tx_sel !== 1'b0) begin errors++; $display("FAIL rst_pre_tx: got %b want 0", tx_sel); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_sel !== 1'b1)   begin errors++; $display("FAIL rst_async_tx: got %b want 1", tx_sel); end
        checks++; if (busy_sel !== 1'b0) begin errors++; $display("FAIL rst_async_busy: got %b want 0", busy_sel); end
        checks++; if (if0.full !== 1'b0) begin errors++; $display("FAIL rst_async_full: got %b want 0", if0.full); end
        step(); step();
        rst_n = 1'b1;
        repeat (20) step();
        checks++; if (tx_sel !== 1'b1 || busy_sel !== 1'b0) begin errors++; $display("FAIL rst_flushed: got tx=%b busy=%b want tx=1 busy=0", tx_sel, busy_sel); end
        write_byte(8'hF0);
        capture(10, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL rst_after_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[9:0] !== {1'b1, 8'hF0, 1'b0}) begin errors++; $display("FAIL rst_after_bits: got %b want %b", bits[9:0], {1'b1, 8'hF0, 1'b0}); end
        checks++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1) begin errors++; $display("FAIL rst_after_end: got busy=%b tx=%b want busy=0 tx=1", busy_sel, tx_sel); end
    endtask

    task automatic test_clken_gaps();
        logic [63:0] bits;
        int bad;
        rand_ck = 1'b1;
        sel = 0;
        write_byte(8'h96);
        capture(10, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL gap0_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[9:0] !== {1'b1, 8'h96, 1'b0}) begin errors++; $display("FAIL gap0_bits: got %b want %b", bits[9:0], {1'b1, 8'h96, 1'b0}); end
        checks++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1) begin errors++; $display("FAIL gap0_end: got busy=%b tx=%b want busy=0 tx=1", busy_sel, tx_sel); end
        sel = 1;
        write_byte(8'h3B);
        capture(11, bits, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL gap1_timing: got %0d bad samples want 0", bad); end
        checks++; if (bits[10:0] !== {1'b1, 1'b1, 8'h3B, 1'b0}) begin errors++; $display("FAIL gap1_bits: got %b want %b", bits[10:0], {1'b1, 1'b1, 8'h3B, 1'b0}); end
        checks++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1) begin errors++; $display("FAIL gap1_end: got busy=%b tx=%b want busy=0 tx=1", busy_sel, tx_sel); end
        rand_ck = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        clken_drv = 1'b0;
        din_drv   = 8'h00;
        wr_drv    = 1'b0;
        clr_drv   = 1'b0;
        sel       = 0;
        rand_ck   = 1'b0;
        ck_edge   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        #1;
        test_reset();
        rst_n = 1'b1;
        step();
        test_single_frame();
        test_back_to_back();
        test_parity_stop();
        test_overflow();
        test_reset_mid_frame();
        test_clken_gaps();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
